// File: rtl/sipo_pkg.sv
// Purpose : shared constants and sizing helpers for the SIPO deserializer slice.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: SIPO_DEFAULT_WIDTH (default word width), sipo_cnt_width() (bit-counter width).
package sipo_pkg;

  // Default parallel word width.
  localparam int SIPO_DEFAULT_WIDTH = 4;

  // Bit-counter width: clog2(width), never narrower than one bit.
  function automatic int sipo_cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : sipo_pkg

// File: rtl/sipo_bit_counter.sv
// Purpose : modulo-WIDTH counter of enabled shifts with a combinational wrap pulse.
// Latency : wrap asserts combinationally in the cycle of the WIDTH-th enabled shift.
// Backpressure: none; en=0 holds the count.
// Ports   : clk, rst (sync, active-high), en (count enable), wrap (count is WIDTH-1 and en=1).
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic wrap
);

  localparam int            CW   = sipo_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  // Explicit compare so non-power-of-two widths wrap at WIDTH-1.
  assign w_wrap = en && (r_cnt == LAST);
  assign wrap   = w_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : (r_cnt + ONE);
    end
  end

endmodule : sipo_bit_counter

// File: rtl/sipo_deserializer.sv
// Purpose : MSB-first serial-in/parallel-out shift register with a frame-complete strobe.
// Latency : each bit appears on parallel one edge after sampling; valid follows the WIDTH-th bit by one edge.
// Backpressure: none; the consumer must take parallel in the valid cycle.
// Ports   : clk, rst (sync, active-high, priority over en), serial, en (shift enable),
//           parallel[WIDTH-1:0] (live shift register), valid (one-cycle frame strobe),
//           parity (only when SIPO_PARITY_EN is defined: XOR of the last complete frame).
// Option  : define SIPO_PARITY_EN to add the parity output and its register.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial,
  input  logic             en,
  output logic [WIDTH-1:0] parallel,
  output logic             valid
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] r_sreg;
  logic             r_valid;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;

  // Next register value; on a wrap edge this is the complete frame.
  assign w_next = {r_sreg[WIDTH-2:0], serial};

  sipo_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .wrap (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg <= '0;
    end else if (en) begin
      r_sreg <= w_next;
    end
  end

  // w_wrap already includes en, so a hold cycle drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_wrap;
    end
  end

  assign parallel = r_sreg;
  assign valid    = r_valid;

`ifdef SIPO_PARITY_EN
  logic r_parity;

  // Captured together with valid and held until the next frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_wrap) begin
      r_parity <= ^w_next;
    end
  end

  assign parity = r_parity;
`endif

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Purpose : directed self-checking bench for sipo_deserializer (WIDTH=4).
// Latency : outputs checked 1 time unit after each rising edge.
// Backpressure: n/a.
// Option  : parity checks are compiled in when SIPO_PARITY_EN is defined.
module tb_sipo_deserializer;

  logic       clk;
  logic       rst;
  logic       serial;
  logic       en;
  logic [3:0] parallel;
  logic       valid;
`ifdef SIPO_PARITY_EN
  logic       parity;
`endif

  int total = 0;
  int bad   = 0;

  sipo_deserializer #(
    .WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .serial   (serial),
    .en       (en),
    .parallel (parallel),
    .valid    (valid)
`ifdef SIPO_PARITY_EN
    ,
    .parity   (parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's inputs, then sample 1 unit after the edge.
  task automatic step(input logic s, input logic e, input logic r);
    serial = s;
    en     = e;
    rst    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Intermediate values while repeating 1,1,0,1 after a 1101 frame.
  logic [3:0] stream_exp [4];
  logic       stream_bit [4];

  initial begin
    stream_exp[0] = 4'b1011; stream_exp[1] = 4'b0111;
    stream_exp[2] = 4'b1110; stream_exp[3] = 4'b1101;
    stream_bit[0] = 1'b1; stream_bit[1] = 1'b1;
    stream_bit[2] = 1'b0; stream_bit[3] = 1'b1;

    serial = 1'b0; en = 1'b0; rst = 1'b1;

    // Reset: two edges, checked after the first.
    @(posedge clk); #1;
    chk("rst_par", parallel, 4'b0000);
    chk("rst_vld", valid, 1'b0);
`ifdef SIPO_PARITY_EN
    chk("rst_parity", parity, 1'b0);
`endif
    step(1'b1, 1'b1, 1'b1);
    chk("rst2_par", parallel, 4'b0000);

    // Single frame 1,1,0,1.
    step(1'b1, 1'b1, 1'b0); chk("f1_b0_par", parallel, 4'b0001); chk("f1_b0_vld", valid, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("f1_b1_par", parallel, 4'b0011); chk("f1_b1_vld", valid, 1'b0);
    step(1'b0, 1'b1, 1'b0); chk("f1_b2_par", parallel, 4'b0110); chk("f1_b2_vld", valid, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("f1_b3_par", parallel, 4'b1101); chk("f1_b3_vld", valid, 1'b1);
`ifdef SIPO_PARITY_EN
    chk("f1_parity", parity, 1'b1);
`endif

    // Continuous stream: 10 more back-to-back frames of 1,1,0,1.
    for (int f = 0; f < 10; f++) begin
      for (int b = 0; b < 4; b++) begin
        step(stream_bit[b], 1'b1, 1'b0);
        chk($sformatf("str_f%0d_b%0d_par", f, b), parallel, stream_exp[b]);
        chk($sformatf("str_f%0d_b%0d_vld", f, b), valid, (b == 3) ? 1'b1 : 1'b0);
      end
    end

    // Enable gap: clear, shift 2 bits, hold 3 cycles with serial toggling / X.
    step(1'b0, 1'b0, 1'b1);
    chk("gap_rst_par", parallel, 4'b0000);
    step(1'b1, 1'b1, 1'b0); chk("gap_b0_par", parallel, 4'b0001);
    step(1'b1, 1'b1, 1'b0); chk("gap_b1_par", parallel, 4'b0011);
    step(1'b0, 1'b0, 1'b0); chk("gap_h0_par", parallel, 4'b0011); chk("gap_h0_vld", valid, 1'b0);
    step(1'b1, 1'b0, 1'b0); chk("gap_h1_par", parallel, 4'b0011); chk("gap_h1_vld", valid, 1'b0);
    step(1'bx, 1'b0, 1'b0); chk("gap_h2_par", parallel, 4'b0011); chk("gap_h2_vld", valid, 1'b0);
    step(1'b0, 1'b1, 1'b0); chk("gap_b2_par", parallel, 4'b0110); chk("gap_b2_vld", valid, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("gap_b3_par", parallel, 4'b1101); chk("gap_b3_vld", valid, 1'b1);
    // Hold straight after a completed frame drops valid.
    step(1'b0, 1'b0, 1'b0); chk("gap_post_par", parallel, 4'b1101); chk("gap_post_vld", valid, 1'b0);

    // Mid-frame reset: 3 bits, reset (with en=1, reset wins), then 1,0,0,1.
    step(1'b1, 1'b1, 1'b0); chk("mid_b0_par", parallel, 4'b1011);
    step(1'b0, 1'b1, 1'b0); chk("mid_b1_par", parallel, 4'b0110);
    step(1'b1, 1'b1, 1'b0); chk("mid_b2_par", parallel, 4'b1101);
    step(1'b1, 1'b1, 1'b1); chk("mid_rst_par", parallel, 4'b0000); chk("mid_rst_vld", valid, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("mid_n0_par", parallel, 4'b0001); chk("mid_n0_vld", valid, 1'b0);
    step(1'b0, 1'b1, 1'b0); chk("mid_n1_par", parallel, 4'b0010); chk("mid_n1_vld", valid, 1'b0);
    step(1'b0, 1'b1, 1'b0); chk("mid_n2_par", parallel, 4'b0100); chk("mid_n2_vld", valid, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("mid_n3_par", parallel, 4'b1001); chk("mid_n3_vld", valid, 1'b1);
`ifdef SIPO_PARITY_EN
    chk("mid_parity", parity, 1'b0);
`endif

    // Frame 1101 then 1001: parity 1, held across gap and partial frame, then 0.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("par1_par", parallel, 4'b1101); chk("par1_vld", valid, 1'b1);
`ifdef SIPO_PARITY_EN
    chk("par1_parity", parity, 1'b1);
`endif
    step(1'b0, 1'b0, 1'b0); chk("par_hold_vld", valid, 1'b0);
`ifdef SIPO_PARITY_EN
    chk("par_hold_parity", parity, 1'b1);
`endif
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    chk("par_mid_parity", parity, 1'b1);
`endif
    step(1'b1, 1'b1, 1'b0); chk("par2_par", parallel, 4'b1001); chk("par2_vld", valid, 1'b1);
`ifdef SIPO_PARITY_EN
    chk("par2_parity", parity, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sipo_deserializer
